// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller.
// Holds the direction encoding used on the dir output and the
// USB HID keycodes that steer the sprite.
package sprite_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/sprite_motion_if.sv
// Keycode-in / position-out bundle between the SoC, the motion block and
// the colour mapper.
// Ports: keycode (to motion), pos_x, pos_y, dir, frame_tick (from motion).
interface sprite_motion_if;
  import sprite_pkg::*;

  logic [7:0] keycode;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  dir_t       dir;
  logic       frame_tick;

  // master: the motion controller, which owns the sprite state
  modport master (
    input  keycode,
    output pos_x,
    output pos_y,
    output dir,
    output frame_tick
  );

  // slave: keycode source and drawing-side consumer
  modport slave (
    output keycode,
    input  pos_x,
    input  pos_y,
    input  dir,
    input  frame_tick
  );

endinterface

// File: rtl/sprite_motion_frame_tick_gen.sv
// Turns the asynchronous active-low vsync into a one-clock frame pulse.
// Ports: clk, reset_n (async, active-low), frame_vs (async in), frame_tick (out).
// A vsync rise before edge k gives frame_tick high for the cycle after edge k+2.
module frame_tick_gen (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_vs,
  output logic frame_tick
);

  logic s1;
  logic s2;
  logic d;

  // Flops reset to 1 (vsync idle) so leaving reset never fakes a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      d          <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      s1         <= frame_vs;
      s2         <= s1;
      d          <= s2;
      frame_tick <= s2 & ~d;  // rising edge = end of the sync pulse
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// Keycode-driven sprite position controller: once per frame picks a
// direction from the keycode and steps the sprite, bouncing off the bounds.
// Ports: clk, reset_n (async, active-low), frame_vs (async vsync), bus
// (keycode in; pos_x, pos_y, dir, frame_tick out). Update lands one clock
// after the frame_tick cycle.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned X_START = 320,
  parameter int unsigned Y_START = 240,
  parameter int unsigned SIZE    = 4,
  parameter int unsigned STEP    = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_vs,
  sprite_motion_if.master bus
);

  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [10:0] REACH   = 11'(SIZE + STEP);
  localparam logic [10:0] X_HI    = 11'(X_MAX);
  localparam logic [10:0] Y_HI    = 11'(Y_MAX);
  localparam logic [10:0] X_LO    = 11'(X_MIN + SIZE + STEP);
  localparam logic [10:0] Y_LO    = 11'(Y_MIN + SIZE + STEP);

  logic       tick;
  dir_t       dir_q, dir_n, cand;
  logic [9:0] x_q, x_n, y_q, y_n;
  logic [10:0] x_ext, y_ext;

  frame_tick_gen u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_vs   (frame_vs),
    .frame_tick (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= STOP;
      x_q   <= 10'(X_START);
      y_q   <= 10'(Y_START);
    end else begin
      dir_q <= dir_n;
      x_q   <= x_n;
      y_q   <= y_n;
    end
  end

  // Widened copies so the bound checks cannot overflow, and LEFT/UP use
  // the additive compare so nothing is ever subtracted below zero.
  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  always_comb begin
    cand  = dir_q;
    dir_n = dir_q;
    x_n   = x_q;
    y_n   = y_q;

    unique case (bus.keycode)
      KEY_W:     cand = UP;
      KEY_S:     cand = DOWN;
      KEY_A:     cand = LEFT;
      KEY_D:     cand = RIGHT;
      KEY_SPACE: cand = STOP;
      default:   cand = dir_q;
    endcase

    // Key chooses the direction first; the bounce test applies to that choice.
    if (tick) begin
      dir_n = cand;
      case (cand)
        RIGHT: begin
          if (x_ext + REACH > X_HI) begin
            dir_n = LEFT;
            x_n   = x_q - STEP10;
          end else begin
            x_n   = x_q + STEP10;
          end
        end
        LEFT: begin
          if (x_ext < X_LO) begin
            dir_n = RIGHT;
            x_n   = x_q + STEP10;
          end else begin
            x_n   = x_q - STEP10;
          end
        end
        DOWN: begin
          if (y_ext + REACH > Y_HI) begin
            dir_n = UP;
            y_n   = y_q - STEP10;
          end else begin
            y_n   = y_q + STEP10;
          end
        end
        UP: begin
          if (y_ext < Y_LO) begin
            dir_n = DOWN;
            y_n   = y_q + STEP10;
          end else begin
            y_n   = y_q - STEP10;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pos_x      = x_q;
  assign bus.pos_y      = y_q;
  assign bus.dir        = dir_q;
  assign bus.frame_tick = tick;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: three instances (default start, start
// near the right edge, start near the left edge), each with its own vsync.
module tb_sprite_motion;
  import sprite_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [2:0] fv;
  logic [7:0] kc [3];
  logic [9:0] ox [3];
  logic [9:0] oy [3];
  logic [2:0] od [3];
  logic       ot [3];

  int checks = 0;
  int passes = 0;
  int frames [3];
  int tcnt [3];

  sprite_motion_if bus0 ();
  sprite_motion_if bus1 ();
  sprite_motion_if bus2 ();

  sprite_motion u_dut0 (
    .clk(clk), .reset_n(reset_n), .frame_vs(fv[0]), .bus(bus0));
  sprite_motion #(.X_START(634)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .frame_vs(fv[1]), .bus(bus1));
  sprite_motion #(.X_START(5)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .frame_vs(fv[2]), .bus(bus2));

  assign bus0.keycode = kc[0];
  assign bus1.keycode = kc[1];
  assign bus2.keycode = kc[2];
  assign ox[0] = bus0.pos_x; assign oy[0] = bus0.pos_y;
  assign ox[1] = bus1.pos_x; assign oy[1] = bus1.pos_y;
  assign ox[2] = bus2.pos_x; assign oy[2] = bus2.pos_y;
  assign od[0] = bus0.dir;   assign ot[0] = bus0.frame_tick;
  assign od[1] = bus1.dir;   assign ot[1] = bus1.frame_tick;
  assign od[2] = bus2.dir;   assign ot[2] = bus2.frame_tick;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (ot[0]) tcnt[0]++;
    if (ot[1]) tcnt[1]++;
    if (ot[2]) tcnt[2]++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Low sync pulse on one instance; the rise is placed just after a falling
  // edge, and the task returns once the position update has landed.
  task automatic do_frame(input int sel);
    @(negedge clk) fv[sel] = 1'b0;
    repeat (3) @(negedge clk);
    fv[sel] = 1'b1;
    repeat (5) @(negedge clk);
    frames[sel]++;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] key;
    int         ex;
    int         ey;
    int         ed;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{0, 8'h00, 320, 240, int'(STOP)};
    tbl[1]  = '{0, 8'h00, 320, 240, int'(STOP)};
    tbl[2]  = '{0, 8'h00, 320, 240, int'(STOP)};
    tbl[3]  = '{0, 8'h07, 321, 240, int'(RIGHT)};
    tbl[4]  = '{0, 8'h07, 322, 240, int'(RIGHT)};
    tbl[5]  = '{0, 8'h07, 323, 240, int'(RIGHT)};
    tbl[6]  = '{0, 8'h07, 324, 240, int'(RIGHT)};
    tbl[7]  = '{0, 8'h07, 325, 240, int'(RIGHT)};
    tbl[8]  = '{0, 8'h00, 326, 240, int'(RIGHT)};
    tbl[9]  = '{0, 8'h00, 327, 240, int'(RIGHT)};
    tbl[10] = '{1, 8'h07, 635, 240, int'(RIGHT)};
    tbl[11] = '{1, 8'h07, 634, 240, int'(LEFT)};
    tbl[12] = '{1, 8'h00, 633, 240, int'(LEFT)};
    tbl[13] = '{1, 8'h00, 632, 240, int'(LEFT)};
    tbl[14] = '{2, 8'h04, 4,   240, int'(LEFT)};
    tbl[15] = '{2, 8'h04, 5,   240, int'(RIGHT)};
    tbl[16] = '{2, 8'h00, 6,   240, int'(RIGHT)};

    fv      = 3'b111;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      kc[i] = 8'h00;
      frames[i] = 0;
    end

    #15;
    chk("reset pos_x", int'(ox[0]), 320);
    chk("reset pos_y", int'(oy[0]), 240);
    chk("reset dir", int'(od[0]), int'(STOP));
    chk("reset frame_tick", int'(ot[0]), 0);
    chk("reset pos_x near right", int'(ox[1]), 634);
    chk("reset pos_x near left", int'(ox[2]), 5);
    #20 reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      kc[tbl[i].sel] = tbl[i].key;
      do_frame(tbl[i].sel);
      chk($sformatf("vec%0d pos_x", i), int'(ox[tbl[i].sel]), tbl[i].ex);
      chk($sformatf("vec%0d pos_y", i), int'(oy[tbl[i].sel]), tbl[i].ey);
      chk($sformatf("vec%0d dir", i), int'(od[tbl[i].sel]), tbl[i].ed);
      if (i == 2) chk("tick count idle frames", tcnt[0], 3);
    end

    // Keycode changes between ticks: only the value present at the tick counts.
    @(negedge clk) fv[0] = 1'b0;
    kc[0] = 8'h1A;
    repeat (2) @(negedge clk);
    kc[0] = 8'h16;
    @(negedge clk) fv[0] = 1'b1;
    @(posedge clk) #1 chk("tick at edge k", int'(ot[0]), 0);
    @(posedge clk) #1 chk("tick at edge k+1", int'(ot[0]), 0);
    @(posedge clk) #1 chk("tick at edge k+2", int'(ot[0]), 1);
    chk("pos_y held at k+2", int'(oy[0]), 240);
    @(posedge clk) #1 chk("tick at edge k+3", int'(ot[0]), 0);
    chk("pos_y at k+3", int'(oy[0]), 241);
    chk("pos_x at k+3", int'(ox[0]), 327);
    chk("dir at k+3", int'(od[0]), int'(DOWN));
    frames[0]++;

    kc[0] = 8'h04;
    repeat (3) @(negedge clk);
    kc[0] = 8'h00;
    do_frame(0);
    chk("ignored mid-frame key pos_y", int'(oy[0]), 242);
    chk("ignored mid-frame key dir", int'(od[0]), int'(DOWN));

    kc[0] = 8'h1A;
    do_frame(0);
    chk("up pos_y", int'(oy[0]), 241);
    kc[0] = 8'h00;
    do_frame(0);
    chk("up persists pos_y", int'(oy[0]), 240);
    chk("up persists dir", int'(od[0]), int'(UP));

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #7 reset_n = 1'b0;
    #1;
    chk("async reset pos_x", int'(ox[0]), 320);
    chk("async reset pos_y", int'(oy[0]), 240);
    chk("async reset dir", int'(od[0]), int'(STOP));
    chk("async reset tick", int'(ot[0]), 0);
    #40;
    @(negedge clk) reset_n = 1'b1;

    kc[0] = 8'h2C;
    do_frame(0);
    chk("space after reset pos_x", int'(ox[0]), 320);
    chk("space after reset pos_y", int'(oy[0]), 240);
    chk("space after reset dir", int'(od[0]), int'(STOP));
    kc[0] = 8'h00;
    do_frame(0);
    chk("stopped stays pos_y", int'(oy[0]), 240);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("tick count dut%0d", i), tcnt[i], frames[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
